// File: rtl/multicycle_controller_p_if.sv
// Controller-to-datapath/memory bundle: instruction fetch, data-memory handshake
// and the datapath control word produced by the multicycle controller.
interface multicycle_controller_p_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int RA_W   = 5
);
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              mem_ack;
  logic              comp_zero;
  logic [2:0]        state;
  logic              ir_load;
  logic [RA_W-1:0]   rd_sel;
  logic [RA_W-1:0]   rs_sel;
  logic [RA_W-1:0]   rt_sel;
  logic [NREG-1:0]   reg_en;
  logic [3:0]        alu_func;
  logic              alu_en;
  logic [4:0]        shamt;
  logic              mem_req;
  logic              mem_rw;
  logic              addr_sel;
  logic              pc_en;
  logic [1:0]        pc_sel;
  logic              sp_en;
  logic              sp_dec;
  logic              done;
  logic              illegal;

  modport master (
    input  instruction, instr_valid, mem_ack, comp_zero,
    output state, ir_load, rd_sel, rs_sel, rt_sel, reg_en, alu_func, alu_en,
           shamt, mem_req, mem_rw, addr_sel, pc_en, pc_sel, sp_en, sp_dec,
           done, illegal
  );

  modport slave (
    output instruction, instr_valid, mem_ack, comp_zero,
    input  state, ir_load, rd_sel, rs_sel, rt_sel, reg_en, alu_func, alu_en,
           shamt, mem_req, mem_rw, addr_sel, pc_en, pc_sel, sp_en, sp_dec,
           done, illegal
  );
endinterface

// File: rtl/multicycle_controller_p.sv
// Multicycle instruction sequencer FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, a data-memory timeout trap and sticky HALT/ERR states.
module multicycle_controller_p #(
  parameter int DATA_W      = 32,
  parameter int NREG        = 32,
  parameter int RA_W        = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_controller_p_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [5:0] OP_LOAD   = 6'h10;
  localparam logic [5:0] OP_STORE  = 6'h11;
  localparam logic [5:0] OP_JUMP   = 6'h12;
  localparam logic [5:0] OP_BRANCH = 6'h13;
  localparam logic [5:0] OP_CALL   = 6'h14;
  localparam logic [5:0] OP_RET    = 6'h15;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  localparam int RD_HI = DATA_W - 7;
  localparam int RS_HI = RD_HI - RA_W;
  localparam int RT_HI = RS_HI - RA_W;
  localparam int SH_HI = RT_HI - RA_W;

  localparam int              CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT_EN ? CNT_W'(MEM_TIMEOUT - 1) : {CNT_W{1'b0}};

  function automatic logic op_legal(input logic [5:0] op);
    return (op <= OP_RET) || (op == OP_HALT);
  endfunction

  logic [2:0]        state_r;
  logic [2:0]        next_state_s;
  logic [DATA_W-1:0] ir_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              illegal_r;
  logic [5:0]        op_s;
  logic [RA_W-1:0]   rd_s;
  logic              is_alu_s;
  logic              timeout_hit_s;
  logic              unused_ir_s;

  assign op_s          = ir_r[DATA_W-1 -: 6];
  assign rd_s          = ir_r[RD_HI -: RA_W];
  assign is_alu_s      = (op_s[5:4] == 2'b00);
  assign timeout_hit_s = TIMEOUT_EN && (cnt_r == CNT_LAST);
  assign unused_ir_s   = ^ir_r[SH_HI-5:0];

  assign bus.state    = state_r;
  assign bus.rd_sel   = rd_s;
  assign bus.rs_sel   = ir_r[RS_HI -: RA_W];
  assign bus.rt_sel   = ir_r[RT_HI -: RA_W];
  assign bus.shamt    = ir_r[SH_HI -: 5];
  assign bus.alu_func = op_s[3:0];
  assign bus.illegal  = illegal_r;

  // Next-state sequencing; memory ack takes priority over the timeout trap
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (bus.instr_valid) next_state_s = S_DECODE;
        else                 next_state_s = S_FETCH;
      end
      S_DECODE: begin
        if (!op_legal(op_s))       next_state_s = S_ERR;
        else if (op_s == OP_HALT)  next_state_s = S_HALT;
        else                       next_state_s = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu_s)                                   next_state_s = S_WB;
        else if (op_s == OP_JUMP || op_s == OP_BRANCH)  next_state_s = S_FETCH;
        else if (op_s >= OP_LOAD && op_s <= OP_RET)     next_state_s = S_MEM;
        else                                            next_state_s = S_ERR;
      end
      S_MEM: begin
        if (bus.mem_ack)        next_state_s = (op_s == OP_LOAD) ? S_WB : S_FETCH;
        else if (timeout_hit_s) next_state_s = S_ERR;
        else                    next_state_s = S_MEM;
      end
      S_WB:    next_state_s = S_FETCH;
      S_HALT:  next_state_s = S_HALT;
      S_ERR:   next_state_s = S_ERR;
      default: next_state_s = S_ERR;
    endcase
  end

  // State, instruction register and sticky trap flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_FETCH;
      ir_r      <= {DATA_W{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      illegal_r <= illegal_r | (next_state_s == S_ERR);
      if (state_r == S_FETCH && bus.instr_valid) ir_r <= bus.instruction;
    end
  end

  // Wait-cycle counter: cleared on entry to MEM, counts cycles without ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_EXEC) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_MEM && !bus.mem_ack) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Datapath control decode; MEM outputs also follow mem_ack
  always_comb begin
    bus.ir_load  = 1'b0;
    bus.reg_en   = {NREG{1'b0}};
    bus.alu_en   = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_rw   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.pc_en    = 1'b0;
    bus.pc_sel   = 2'd0;
    bus.sp_en    = 1'b0;
    bus.sp_dec   = 1'b0;
    bus.done     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (bus.instr_valid) bus.ir_load = 1'b1;
        else                 bus.ir_load = 1'b0;
      end
      S_EXEC: begin
        if (is_alu_s) begin
          bus.alu_en = 1'b1;
        end else if (op_s == OP_JUMP) begin
          bus.pc_en  = 1'b1;
          bus.pc_sel = 2'd1;
          bus.done   = 1'b1;
        end else if (op_s == OP_BRANCH) begin
          bus.pc_en  = 1'b1;
          bus.pc_sel = bus.comp_zero ? 2'd1 : 2'd0;
          bus.done   = 1'b1;
        end else begin
          bus.alu_en = 1'b0;
        end
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.mem_rw   = (op_s == OP_STORE) || (op_s == OP_CALL);
        bus.addr_sel = (op_s == OP_CALL) || (op_s == OP_RET);
        if (bus.mem_ack) begin
          case (op_s)
            OP_STORE: begin
              bus.pc_en = 1'b1;
              bus.done  = 1'b1;
            end
            OP_CALL: begin
              bus.sp_en  = 1'b1;
              bus.sp_dec = 1'b1;
              bus.pc_en  = 1'b1;
              bus.pc_sel = 2'd1;
              bus.done   = 1'b1;
            end
            OP_RET: begin
              bus.sp_en  = 1'b1;
              bus.pc_en  = 1'b1;
              bus.pc_sel = 2'd2;
              bus.done   = 1'b1;
            end
            default: bus.done = 1'b0;
          endcase
        end else begin
          bus.done = 1'b0;
        end
      end
      S_WB: begin
        // r0 is read-only, so rd=0 writes nothing
        if (rd_s != {RA_W{1'b0}}) bus.reg_en = {{(NREG-1){1'b0}}, 1'b1} << rd_s;
        else                      bus.reg_en = {NREG{1'b0}};
        bus.pc_en = 1'b1;
        bus.done  = 1'b1;
      end
      default: bus.done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller_p.sv
// Scenario bench for multicycle_controller_p: a retirement scoreboard plus
// per-scenario cycle traces checked against hand-derived expectations.
module tb_multicycle_controller_p;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  multicycle_controller_p_if #(.DATA_W(32), .NREG(32), .RA_W(5)) bus ();

  multicycle_controller_p #(.DATA_W(32), .NREG(32), .RA_W(5), .MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] reg_en;
    logic [1:0]  pc_sel;
    logic        sp_en;
    logic        sp_dec;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  state;
    logic        ir_load;
    logic [31:0] reg_en;
    logic [3:0]  alu_func;
    logic        alu_en;
    logic [4:0]  shamt, rd, rs, rt;
    logic        mem_req, mem_rw, addr_sel, pc_en;
    logic [1:0]  pc_sel;
    logic        sp_en, sp_dec, done, illegal;
  } snap_t;

  exp_t  sb[$];
  snap_t snap[64];

  task automatic push_exp(input logic [31:0] re, input logic [1:0] ps, input logic se,
                          input logic sd, input int lat);
    exp_t e;
    e.reg_en = re; e.pc_sel = ps; e.sp_en = se; e.sp_dec = sd; e.lat = lat;
    sb.push_back(e);
  endtask

  // Issue one instruction and record ncyc cycles; retirements are scored against the queue.
  task automatic run_instr(input logic [31:0] ins, input int ack_at, input logic cz, input int ncyc);
    int   mem_idx;
    exp_t e;
    mem_idx = 0;
    for (int i = 0; i < ncyc; i++) begin
      bus.comp_zero = cz;
      if (i == 0) begin
        bus.instr_valid = 1'b1;
        bus.instruction = ins;
      end else begin
        bus.instr_valid = (bus.state == 3'd0) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.instruction = $urandom;
      end
      if (bus.state == 3'd3) begin
        bus.mem_ack = (mem_idx == ack_at);
        mem_idx++;
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      snap[i] = '{state: bus.state, ir_load: bus.ir_load, reg_en: bus.reg_en,
                  alu_func: bus.alu_func, alu_en: bus.alu_en, shamt: bus.shamt,
                  rd: bus.rd_sel, rs: bus.rs_sel, rt: bus.rt_sel, mem_req: bus.mem_req,
                  mem_rw: bus.mem_rw, addr_sel: bus.addr_sel, pc_en: bus.pc_en,
                  pc_sel: bus.pc_sel, sp_en: bus.sp_en, sp_dec: bus.sp_dec,
                  done: bus.done, illegal: bus.illegal};
      if (bus.done === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done ins=%h cyc=%0d got done=1 want no retirement", ins, i);
        end else begin
          e = sb.pop_front();
          if (i + 1 !== e.lat) begin
            bad++;
            $display("FAIL latency ins=%h got=%0d want=%0d", ins, i + 1, e.lat);
          end
          total++;
          if (bus.reg_en !== e.reg_en) begin
            bad++;
            $display("FAIL reg_en ins=%h got=%h want=%h", ins, bus.reg_en, e.reg_en);
          end
          total++;
          if (bus.pc_sel !== e.pc_sel || bus.pc_en !== 1'b1) begin
            bad++;
            $display("FAIL pc ins=%h got sel=%0d en=%b want sel=%0d en=1", ins, bus.pc_sel, bus.pc_en, e.pc_sel);
          end
          total++;
          if (bus.sp_en !== e.sp_en || bus.sp_dec !== e.sp_dec) begin
            bad++;
            $display("FAIL sp ins=%h got en=%b dec=%b want en=%b dec=%b", ins, bus.sp_en, bus.sp_dec, e.sp_en, e.sp_dec);
          end
        end
      end
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL missing_done ins=%h got %0d pending retirements want 0", ins, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_trace(input string name, input logic [2:0] exp_st[], input int first);
    for (int k = 0; k < exp_st.size(); k++) begin
      total++;
      if (snap[first + k].state !== exp_st[k]) begin
        bad++;
        $display("FAIL %s_state cyc=%0d got=%0d want=%0d", name, first + k, snap[first + k].state, exp_st[k]);
      end
    end
  endtask

  task automatic test_reset();
    logic [99:0] outs;
    bus.instr_valid = 1'b0; bus.mem_ack = 1'b0; bus.comp_zero = 1'b0; bus.instruction = 32'h0;
    reset = 1'b1;
    #3;
    outs = {bus.ir_load, bus.reg_en, bus.alu_func, bus.alu_en, bus.shamt, bus.mem_req,
            bus.mem_rw, bus.addr_sel, bus.pc_en, bus.pc_sel, bus.sp_en, bus.sp_dec,
            bus.done, bus.illegal, bus.rd_sel, bus.rs_sel, bus.rt_sel};
    total++;
    if (bus.state !== 3'd0 || outs !== 100'd0) begin
      bad++;
      $display("FAIL reset_outputs got state=%0d outs=%h want state=0 outs=0", bus.state, outs);
    end
    do_reset();
    total++;
    if (bus.state !== 3'd0 || bus.ir_load !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got state=%0d ir_load=%b want 0 0", bus.state, bus.ir_load);
    end
  endtask

  task automatic test_alu();
    push_exp(32'h0000_0008, 2'd0, 1'b0, 1'b0, 4);
    run_instr(32'h1461_1100, -1, 1'b0, 6);
    check_trace("alu", '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0}, 0);
    total++;
    if (snap[0].ir_load !== 1'b1) begin
      bad++; $display("FAIL alu_ir_load got=%b want=1", snap[0].ir_load);
    end
    total++;
    if (snap[1].alu_func !== 4'd5 || snap[1].rd !== 5'd3 || snap[1].rs !== 5'd1 ||
        snap[1].rt !== 5'd2 || snap[1].shamt !== 5'd4) begin
      bad++;
      $display("FAIL alu_fields got func=%0d rd=%0d rs=%0d rt=%0d sh=%0d want 5 3 1 2 4",
               snap[1].alu_func, snap[1].rd, snap[1].rs, snap[1].rt, snap[1].shamt);
    end
    total++;
    if (snap[2].alu_en !== 1'b1 || snap[3].alu_en !== 1'b0) begin
      bad++; $display("FAIL alu_en got exec=%b wb=%b want 1 0", snap[2].alu_en, snap[3].alu_en);
    end
  endtask

  task automatic test_load();
    int nreq;
    nreq = 0;
    push_exp(32'h0000_0080, 2'd0, 1'b0, 1'b0, 7);
    run_instr(32'h40E2_0000, 2, 1'b0, 9);
    check_trace("load", '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0}, 0);
    for (int k = 0; k < 9; k++) if (snap[k].mem_req === 1'b1 && snap[k].mem_rw === 1'b0) nreq++;
    total++;
    if (nreq !== 3) begin
      bad++; $display("FAIL load_mem_req got=%0d cycles want=3", nreq);
    end
  endtask

  task automatic test_branch();
    push_exp(32'h0, 2'd1, 1'b0, 1'b0, 3);
    run_instr(32'h4C00_0000, -1, 1'b1, 5);
    check_trace("branch_t", '{3'd0, 3'd1, 3'd2, 3'd0}, 0);
    push_exp(32'h0, 2'd0, 1'b0, 1'b0, 3);
    run_instr(32'h4C00_0000, -1, 1'b0, 5);
    total++;
    if (snap[2].pc_sel !== 2'd0 || snap[2].done !== 1'b1) begin
      bad++; $display("FAIL branch_nt got sel=%0d done=%b want 0 1", snap[2].pc_sel, snap[2].done);
    end
  endtask

  task automatic test_call_ret();
    push_exp(32'h0, 2'd1, 1'b1, 1'b1, 4);
    run_instr(32'h5000_0000, 0, 1'b0, 6);
    total++;
    if (snap[3].state !== 3'd3 || snap[3].mem_req !== 1'b1 || snap[3].mem_rw !== 1'b1 ||
        snap[3].addr_sel !== 1'b1 || snap[4].state !== 3'd0) begin
      bad++;
      $display("FAIL call_mem got st=%0d req=%b rw=%b as=%b next=%0d want 3 1 1 1 0",
               snap[3].state, snap[3].mem_req, snap[3].mem_rw, snap[3].addr_sel, snap[4].state);
    end
    push_exp(32'h0, 2'd2, 1'b1, 1'b0, 5);
    run_instr(32'h5400_0000, 1, 1'b0, 7);
    total++;
    if (snap[4].mem_rw !== 1'b0 || snap[4].addr_sel !== 1'b1 || snap[3].sp_en !== 1'b0) begin
      bad++;
      $display("FAIL ret_mem got rw=%b as=%b early_sp=%b want 0 1 0", snap[4].mem_rw, snap[4].addr_sel, snap[3].sp_en);
    end
  endtask

  task automatic test_back_to_back();
    push_exp(32'h0, 2'd1, 1'b0, 1'b0, 3);
    run_instr(32'h4800_0000, -1, 1'b0, 4);
    push_exp(32'h0, 2'd0, 1'b0, 1'b0, 4);
    run_instr(32'h4400_0000, 0, 1'b0, 5);
    total++;
    if (snap[3].mem_rw !== 1'b1 || snap[3].addr_sel !== 1'b0) begin
      bad++; $display("FAIL store_mem got rw=%b as=%b want 1 0", snap[3].mem_rw, snap[3].addr_sel);
    end
    push_exp(32'h0, 2'd0, 1'b0, 1'b0, 4);
    run_instr(32'h0000_0000, -1, 1'b0, 5);
  endtask

  task automatic test_timeout();
    int nreq;
    nreq = 0;
    run_instr(32'h4400_0000, -1, 1'b0, 22);
    for (int k = 0; k < 22; k++) if (snap[k].mem_req === 1'b1) nreq++;
    total++;
    if (nreq !== 16) begin
      bad++; $display("FAIL timeout_mem_cycles got=%0d want=16", nreq);
    end
    check_trace("timeout", '{3'd3, 3'd3, 3'd6, 3'd6}, 17);
    total++;
    if (snap[18].illegal !== 1'b0 || snap[19].illegal !== 1'b1 || snap[21].illegal !== 1'b1) begin
      bad++; $display("FAIL timeout_illegal got %b%b%b want 011", snap[18].illegal, snap[19].illegal, snap[21].illegal);
    end
    run_instr(32'h1461_1100, 0, 1'b1, 5);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (snap[k].state !== 3'd6 || snap[k].ir_load !== 1'b0 || snap[k].pc_en !== 1'b0 || snap[k].illegal !== 1'b1) begin
        bad++;
        $display("FAIL err_sticky cyc=%0d got st=%0d ld=%b pc=%b ill=%b want 6 0 0 1",
                 k, snap[k].state, snap[k].ir_load, snap[k].pc_en, snap[k].illegal);
      end
    end
    do_reset();
    run_instr(32'h4400_0000, -1, 1'b0, 6);
    total++;
    if (snap[5].state !== 3'd3 || snap[5].mem_req !== 1'b1) begin
      bad++; $display("FAIL pre_abort got st=%0d req=%b want 3 1", snap[5].state, snap[5].mem_req);
    end
    bus.mem_ack = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++;
    if (bus.state !== 3'd0 || bus.mem_req !== 1'b0 || bus.illegal !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL async_abort got st=%0d req=%b ill=%b done=%b want 0 0 0 0", bus.state, bus.mem_req, bus.illegal, bus.done);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_traps();
    int ndone;
    run_instr(32'h8000_0000, -1, 1'b0, 4);
    check_trace("illegal_op", '{3'd1, 3'd6, 3'd6}, 1);
    total++;
    if (snap[1].illegal !== 1'b0 || snap[2].illegal !== 1'b1) begin
      bad++; $display("FAIL illegal_flag got %b%b want 01", snap[1].illegal, snap[2].illegal);
    end
    do_reset();
    ndone = 0;
    run_instr(32'hFC00_0000, 0, 1'b1, 8);
    for (int k = 0; k < 8; k++) if (snap[k].done === 1'b1) ndone++;
    check_trace("halt", '{3'd1, 3'd5, 3'd5}, 1);
    total++;
    if (ndone !== 0 || snap[7].state !== 3'd5 || snap[7].illegal !== 1'b0 || snap[7].pc_en !== 1'b0 ||
        snap[7].mem_req !== 1'b0 || snap[7].ir_load !== 1'b0) begin
      bad++;
      $display("FAIL halt_hold got done=%0d st=%0d ill=%b pc=%b req=%b ld=%b want 0 5 0 0 0 0",
               ndone, snap[7].state, snap[7].illegal, snap[7].pc_en, snap[7].mem_req, snap[7].ir_load);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_call_ret();
    test_back_to_back();
    test_timeout();
    test_traps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got no completion want finish");
    $fatal(1);
  end

endmodule
